// File: rtl/mem_xbar_n_pkg.sv
// Shared definitions for the mem_xbar_n crossbar.
//  - state_t         : crossbar FSM states (also exported on the debug port)
//  - DEFAULT_TIMEOUT : default number of WAIT cycles before a slave is declared dead
//  - width_min1()    : clog2 that never returns 0, for counters/indices that may degenerate
package mem_xbar_n_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int DEFAULT_TIMEOUT = 255;

  function automatic int width_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_xbar_n_if.sv
// Bus bundle between a CPU data port, the crossbar and NUM_SLV slaves.
// Ports (all signals carry the crossbar-relative i_/o_ names):
//   CPU side   : i_req, o_ready, i_addr, i_data, i_wren, i_mask, o_rvalid, o_rdata, o_err
//   slave side : o_s_req, o_s_addr, o_s_data, o_s_mask, o_s_wren, i_s_ack, i_s_rdata
// Modports:
//   slave  : the crossbar's view (it is the slave of the CPU request channel)
//   master : the environment's view (CPU plus the attached memory slaves)
//
// Handshake: a request transfers on a rising clk edge where i_req && o_ready. The
// master holds i_req and its payload stable until that edge. Exactly one response
// follows per accepted request as a single-cycle o_rvalid strobe; no back-pressure
// on the response. Towards slaves, o_s_req[k] stays high with stable o_s_* until the
// edge where i_s_ack[k] is high (or the crossbar gives up); ack is sampled only then.
interface mem_xbar_n_if #(
  parameter int NUM_SLV = 4,
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic                      i_req;
  logic                      o_ready;
  logic [ADDR_W-1:0]         i_addr;
  logic [DATA_W-1:0]         i_data;
  logic                      i_wren;
  logic [MASK_W-1:0]         i_mask;
  logic                      o_rvalid;
  logic [DATA_W-1:0]         o_rdata;
  logic                      o_err;

  logic [NUM_SLV-1:0]        o_s_req;
  logic [ADDR_W-1:0]         o_s_addr;
  logic [DATA_W-1:0]         o_s_data;
  logic [MASK_W-1:0]         o_s_mask;
  logic                      o_s_wren;
  logic [NUM_SLV-1:0]        i_s_ack;
  logic [NUM_SLV*DATA_W-1:0] i_s_rdata;

  modport slave (
    input  i_req, i_addr, i_data, i_wren, i_mask, i_s_ack, i_s_rdata,
    output o_ready, o_rvalid, o_rdata, o_err,
           o_s_req, o_s_addr, o_s_data, o_s_mask, o_s_wren
  );

  modport master (
    output i_req, i_addr, i_data, i_wren, i_mask, i_s_ack, i_s_rdata,
    input  o_ready, o_rvalid, o_rdata, o_err,
           o_s_req, o_s_addr, o_s_data, o_s_mask, o_s_wren
  );

endinterface

// File: rtl/mem_xbar_n_decode.sv
// Combinational address decoder for mem_xbar_n.
// Ports:
//   addr     in  ADDR_W   word address from the CPU
//   hit      out 1        address falls in at least one region
//   sel      out NUM_SLV  one-hot winning region (0 when no hit)
//   idx      out IDX_W    binary index of the winning region
//   rel_addr out ADDR_W   addr - START of the winning region
// Regions may overlap; the lowest-numbered matching region wins.
module mem_xbar_n_decode #(
  parameter int                          NUM_SLV      = 4,
  parameter int                          ADDR_W       = 30,
  parameter int                          IDX_W        = 2,
  parameter logic [NUM_SLV*ADDR_W-1:0]   REGION_START = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0]   REGION_LIMIT = '0
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic               hit,
  output logic [NUM_SLV-1:0] sel,
  output logic [IDX_W-1:0]   idx,
  output logic [ADDR_W-1:0]  rel_addr
);

  always_comb begin
    hit      = 1'b0;
    sel      = '0;
    idx      = '0;
    rel_addr = '0;
    // Walk from the highest region down so the lowest matching one is written last.
    for (int k = NUM_SLV - 1; k >= 0; k--) begin
      if ((addr >= REGION_START[k*ADDR_W +: ADDR_W]) &&
          (addr <= REGION_LIMIT[k*ADDR_W +: ADDR_W])) begin
        hit      = 1'b1;
        sel      = '0;
        sel[k]   = 1'b1;
        idx      = IDX_W'(k);
        // Cannot wrap: addr >= START on this branch.
        rel_addr = addr - REGION_START[k*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/mem_xbar_n.sv
// N-region crossbar between one CPU data port and NUM_SLV memory/MMIO slaves.
// Ports:
//   clk        in   clock, all state on posedge
//   rst        in   synchronous active-high reset
//   bus        if   mem_xbar_n_if.slave: CPU request/response + shared slave bus
//   dbg_state  out  current FSM state
// One transaction is in flight at a time. A mapped request is forwarded to the
// selected slave with a region-relative address and completes on that slave's ack
// or after TIMEOUT WAIT cycles (error). Unmapped requests return an error response
// one cycle after acceptance without touching any slave. All outputs are registered.
module mem_xbar_n
  import mem_xbar_n_pkg::*;
#(
  parameter int                        NUM_SLV      = 4,
  parameter int                        ADDR_W       = 30,
  parameter int                        DATA_W       = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0] REGION_START = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0] REGION_LIMIT = '0,
  parameter int                        TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  mem_xbar_n_if.slave        bus,
  output state_t             dbg_state
);

  localparam int MASK_W = DATA_W / 8;
  localparam int IDX_W  = width_min1(NUM_SLV);
  localparam int CNT_W  = width_min1(TIMEOUT + 1);
  // Value the counter holds during the last permitted WAIT cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  // Decoder outputs
  logic               dec_hit;
  logic [NUM_SLV-1:0] dec_sel;
  logic [IDX_W-1:0]   dec_idx;
  logic [ADDR_W-1:0]  dec_rel;

  mem_xbar_n_decode #(
    .NUM_SLV      (NUM_SLV),
    .ADDR_W       (ADDR_W),
    .IDX_W        (IDX_W),
    .REGION_START (REGION_START),
    .REGION_LIMIT (REGION_LIMIT)
  ) u_decode (
    .addr     (bus.i_addr),
    .hit      (dec_hit),
    .sel      (dec_sel),
    .idx      (dec_idx),
    .rel_addr (dec_rel)
  );

  // State and registered outputs
  state_t             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [IDX_W-1:0]   idx_q,    idx_d;
  logic               ready_q,  ready_d;
  logic               rvalid_q, rvalid_d;
  logic               err_q,    err_d;
  logic [DATA_W-1:0]  rdata_q,  rdata_d;
  logic [NUM_SLV-1:0] s_req_q,  s_req_d;
  logic [ADDR_W-1:0]  s_addr_q, s_addr_d;
  logic [DATA_W-1:0]  s_data_q, s_data_d;
  logic [MASK_W-1:0]  s_mask_q, s_mask_d;
  logic               s_wren_q, s_wren_d;

  // Only the selected slave's ack and read data are ever looked at.
  logic               ack_sel;
  logic [DATA_W-1:0]  rdata_sel;

  assign ack_sel   = bus.i_s_ack[idx_q];
  assign rdata_sel = bus.i_s_rdata[idx_q*DATA_W +: DATA_W];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    ready_d  = ready_q;
    rvalid_d = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    s_req_d  = s_req_q;
    s_addr_d = s_addr_q;
    s_data_d = s_data_q;
    s_mask_d = s_mask_q;
    s_wren_d = s_wren_q;

    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (bus.i_req && ready_q) begin
          ready_d = 1'b0;
          if (dec_hit) begin
            s_req_d  = dec_sel;
            s_addr_d = dec_rel;
            s_data_d = bus.i_data;
            s_mask_d = bus.i_mask;
            s_wren_d = bus.i_wren;
            idx_d    = dec_idx;
            cnt_d    = '0;
            state_d  = S_WAIT;
          end else begin
            rvalid_d = 1'b1;
            err_d    = 1'b1;
            rdata_d  = '0;
            state_d  = S_RESP;
          end
        end
      end

      S_WAIT: begin
        ready_d = 1'b0;
        // Ack is checked first so a last-cycle ack beats the timeout.
        if (ack_sel) begin
          rvalid_d = 1'b1;
          err_d    = 1'b0;
          rdata_d  = s_wren_q ? '0 : rdata_sel;
          s_req_d  = '0;
          s_wren_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          rvalid_d = 1'b1;
          err_d    = 1'b1;
          rdata_d  = '0;
          s_req_d  = '0;
          s_wren_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        ready_d  = 1'b1;
        s_req_d  = '0;
        s_wren_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      s_req_q  <= '0;
      s_addr_q <= '0;
      s_data_q <= '0;
      s_mask_q <= '0;
      s_wren_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      s_req_q  <= s_req_d;
      s_addr_q <= s_addr_d;
      s_data_q <= s_data_d;
      s_mask_q <= s_mask_d;
      s_wren_q <= s_wren_d;
    end
  end

  assign bus.o_ready  = ready_q;
  assign bus.o_rvalid = rvalid_q;
  assign bus.o_err    = err_q;
  assign bus.o_rdata  = rdata_q;
  assign bus.o_s_req  = s_req_q;
  assign bus.o_s_addr = s_addr_q;
  assign bus.o_s_data = s_data_q;
  assign bus.o_s_mask = s_mask_q;
  assign bus.o_s_wren = s_wren_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_xbar_n.sv
module tb_mem_xbar_n;
  import mem_xbar_n_pkg::*;

  localparam int NUM_SLV = 2;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  mem_xbar_n_if #(.NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
  mem_xbar_n_if #(.NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();
  state_t dbg_a, dbg_b;

  // Normal map: region0 [0x0000,0x0FFF], region1 [0x4000,0x40FF]
  mem_xbar_n #(
    .NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .REGION_START({16'h4000, 16'h0000}),
    .REGION_LIMIT({16'h40FF, 16'h0FFF}),
    .TIMEOUT(TIMEOUT)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a), .dbg_state(dbg_a));

  // Overlapping map: both regions [0x0000,0x0FFF]
  mem_xbar_n #(
    .NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .REGION_START({16'h0000, 16'h0000}),
    .REGION_LIMIT({16'h0FFF, 16'h0FFF}),
    .TIMEOUT(TIMEOUT)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b), .dbg_state(dbg_b));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- vectors and reference model ----------------
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              wren;
    logic [DATA_W-1:0] data;
    logic [3:0]        mask;
    int                ack_dly;   // ack on this WAIT cycle of the target slave; 0 = never
    logic [DATA_W-1:0] srd;       // read data the target slave returns
    logic [1:0]        exp_sel;
    logic [ADDR_W-1:0] exp_saddr;
    int                exp_reqc;  // cycles o_s_req stays high
    logic              exp_err;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(input logic [ADDR_W-1:0] a, input logic w, input logic [31:0] d,
                              input logic [3:0] m, input int dly, input logic [31:0] srd,
                              input logic [1:0] sel, input logic [ADDR_W-1:0] sa, input int rc,
                              input logic er, input logic [31:0] rd);
    vec_t v;
    v.addr = a; v.wren = w; v.data = d; v.mask = m; v.ack_dly = dly; v.srd = srd;
    v.exp_sel = sel; v.exp_saddr = sa; v.exp_reqc = rc; v.exp_err = er; v.exp_rdata = rd;
    return v;
  endfunction

  // Memory map as the bench sees it.
  int map_start[2] = '{32'h0000, 32'h4000};
  int map_limit[2] = '{32'h0FFF, 32'h40FF};

  function automatic vec_t model(input logic [ADDR_W-1:0] a, input logic w, input logic [31:0] d,
                                 input logic [3:0] m, input int dly, input logic [31:0] srd);
    vec_t v;
    int   r;
    r = -1;
    for (int k = 1; k >= 0; k--)
      if (int'(a) >= map_start[k] && int'(a) <= map_limit[k]) r = k;
    v = mk(a, w, d, m, dly, srd, 2'b00, '0, 0, 1'b1, '0);
    if (r >= 0) begin
      v.exp_sel   = 2'(1 << r);
      v.exp_saddr = ADDR_W'(int'(a) - map_start[r]);
      if (dly >= 1 && dly <= TIMEOUT) begin
        v.exp_reqc  = dly;
        v.exp_err   = 1'b0;
        v.exp_rdata = w ? 32'h0 : srd;
      end else begin
        v.exp_reqc = TIMEOUT;
      end
    end
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus_a.i_req = 0; bus_a.i_addr = '0; bus_a.i_data = '0; bus_a.i_wren = 0; bus_a.i_mask = '0;
    bus_a.i_s_ack = '0; bus_a.i_s_rdata = '0;
    bus_b.i_req = 0; bus_b.i_addr = '0; bus_b.i_data = '0; bus_b.i_wren = 0; bus_b.i_mask = '0;
    bus_b.i_s_ack = '0; bus_b.i_s_rdata = '0;
  endtask

  task automatic run_txn(input vec_t v);
    int   guard, lat, reqc;
    logic seen;
    logic [31:0] rd;
    logic er;
    guard = 0;
    while (bus_a.o_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    chk("ready_before", 64'(bus_a.o_ready), 64'(1));
    // Non-target slave returns the inverse, so a wrong slice is visible.
    if (v.exp_sel == 2'b10) bus_a.i_s_rdata = {v.srd, ~v.srd};
    else                    bus_a.i_s_rdata = {~v.srd, v.srd};
    bus_a.i_req = 1; bus_a.i_addr = v.addr; bus_a.i_wren = v.wren;
    bus_a.i_data = v.data; bus_a.i_mask = v.mask;
    @(posedge clk); #1;
    bus_a.i_req = 0;
    lat = 0; reqc = 0; seen = 0; rd = '0; er = 0;
    for (int c = 1; c <= TIMEOUT + 4 && !seen; c++) begin
      if (bus_a.o_rvalid === 1'b1) begin
        seen = 1; lat = c; rd = bus_a.o_rdata; er = bus_a.o_err;
        chk("s_req_in_resp", 64'(bus_a.o_s_req), 64'(0));
      end else begin
        chk("ready_busy", 64'(bus_a.o_ready), 64'(0));
        if (bus_a.o_s_req != 0) begin
          reqc++;
          chk("s_req", 64'(bus_a.o_s_req), 64'(v.exp_sel));
          chk("s_addr", 64'(bus_a.o_s_addr), 64'(v.exp_saddr));
          chk("s_wren", 64'(bus_a.o_s_wren), 64'(v.wren));
          chk("s_data", 64'(bus_a.o_s_data), 64'(v.data));
          chk("s_mask", 64'(bus_a.o_s_mask), 64'(v.mask));
          if (reqc == v.ack_dly) bus_a.i_s_ack = v.exp_sel;
        end else begin
          chk("s_wren_no_req", 64'(bus_a.o_s_wren), 64'(0));
        end
        @(posedge clk); #1;
        bus_a.i_s_ack = '0;
      end
    end
    chk("rvalid_seen", 64'(seen), 64'(1));
    if (seen) begin
      chk("latency", 64'(lat), 64'((v.exp_sel == 0) ? 1 : v.exp_reqc + 1));
      chk("err", 64'(er), 64'(v.exp_err));
      chk("rdata", 64'(rd), 64'(v.exp_rdata));
      chk("req_cycles", 64'(reqc), 64'(v.exp_reqc));
    end
    @(posedge clk); #1;
    chk("rvalid_one_cycle", 64'(bus_a.o_rvalid), 64'(0));
    chk("ready_after", 64'(bus_a.o_ready), 64'(1));
    chk("rdata_held", 64'(bus_a.o_rdata), 64'(v.exp_rdata));
  endtask

  // ---------------- test ----------------
  vec_t vecs[10];

  initial begin
    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_ready", 64'(bus_a.o_ready), 64'(1));
    chk("rst_rvalid", 64'(bus_a.o_rvalid), 64'(0));
    chk("rst_err", 64'(bus_a.o_err), 64'(0));
    chk("rst_rdata", 64'(bus_a.o_rdata), 64'(0));
    chk("rst_s_req", 64'(bus_a.o_s_req), 64'(0));
    chk("rst_s_addr", 64'(bus_a.o_s_addr), 64'(0));
    chk("rst_s_data", 64'(bus_a.o_s_data), 64'(0));
    chk("rst_s_mask", 64'(bus_a.o_s_mask), 64'(0));
    chk("rst_s_wren", 64'(bus_a.o_s_wren), 64'(0));
    chk("rst_state", 64'(dbg_a), 64'(S_IDLE));
    chk("rst_b_ready", 64'(bus_b.o_ready), 64'(1));
    rst = 0;
    @(posedge clk); #1;

    // Table-driven transactions on the normal map
    vecs[0] = mk(16'h0010, 1, 32'hCAFEF00D, 4'hF, 1, 32'h11111111, 2'b01, 16'h0010, 1, 0, 32'h0);
    vecs[1] = mk(16'h4003, 0, 32'h0,        4'hF, 3, 32'hDEADBEEF, 2'b10, 16'h0003, 3, 0, 32'hDEADBEEF);
    vecs[2] = mk(16'h2000, 0, 32'h0,        4'hF, 1, 32'h22222222, 2'b00, 16'h0000, 0, 1, 32'h0);
    vecs[3] = mk(16'h4000, 0, 32'h0,        4'hF, 0, 32'h33333333, 2'b10, 16'h0000, 8, 1, 32'h0);
    vecs[4] = mk(16'h4000, 0, 32'h0,        4'hF, 8, 32'h12345678, 2'b10, 16'h0000, 8, 0, 32'h12345678);
    vecs[5] = mk(16'h0FFF, 0, 32'h0,        4'h1, 2, 32'hA5A5A5A5, 2'b01, 16'h0FFF, 2, 0, 32'hA5A5A5A5);
    vecs[6] = mk(16'h40FF, 0, 32'h0,        4'hF, 1, 32'h0BADF00D, 2'b10, 16'h00FF, 1, 0, 32'h0BADF00D);
    vecs[7] = mk(16'h4100, 0, 32'h0,        4'hF, 1, 32'h44444444, 2'b00, 16'h0000, 0, 1, 32'h0);
    vecs[8] = mk(16'h3FFF, 1, 32'h77777777, 4'hF, 1, 32'h55555555, 2'b00, 16'h0000, 0, 1, 32'h0);
    vecs[9] = mk(16'h4080, 1, 32'h55AA55AA, 4'h3, 9, 32'h66666666, 2'b10, 16'h0080, 8, 1, 32'h0);
    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Randomized transactions against the reference model
    for (int i = 0; i < 24; i++) begin
      logic [ADDR_W-1:0] a;
      int kind;
      kind = $urandom_range(0, 3);
      case (kind)
        0:       a = ADDR_W'($urandom_range(16'h0000, 16'h0FFF));
        1:       a = ADDR_W'($urandom_range(16'h4000, 16'h40FF));
        2:       a = ADDR_W'($urandom_range(16'h1000, 16'h3FFF));
        default: a = ADDR_W'($urandom_range(16'h4100, 16'hFFFF));
      endcase
      run_txn(model(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(1, TIMEOUT + 2), $urandom));
    end

    // Ack while idle is ignored
    bus_a.i_s_ack = 2'b11;
    @(posedge clk); #1;
    bus_a.i_s_ack = '0;
    chk("idle_ack_rvalid", 64'(bus_a.o_rvalid), 64'(0));
    chk("idle_ack_ready", 64'(bus_a.o_ready), 64'(1));

    // Request held high: not accepted during RESP, accepted again once idle
    bus_a.i_req = 1; bus_a.i_addr = 16'h2000; bus_a.i_wren = 0;
    @(posedge clk); #1;
    chk("hold_rvalid1", 64'(bus_a.o_rvalid), 64'(1));
    chk("hold_ready_resp", 64'(bus_a.o_ready), 64'(0));
    @(posedge clk); #1;
    chk("hold_rvalid_gap", 64'(bus_a.o_rvalid), 64'(0));
    chk("hold_ready_idle", 64'(bus_a.o_ready), 64'(1));
    @(posedge clk); #1;
    chk("hold_rvalid2", 64'(bus_a.o_rvalid), 64'(1));
    bus_a.i_req = 0;
    @(posedge clk); #1;
    chk("hold_rvalid_end", 64'(bus_a.o_rvalid), 64'(0));

    // Reset during WAIT abandons the request; a late ack is ignored
    bus_a.i_req = 1; bus_a.i_addr = 16'h4010; bus_a.i_wren = 1;
    @(posedge clk); #1;
    bus_a.i_req = 0;
    chk("rstw_s_req", 64'(bus_a.o_s_req), 64'(2'b10));
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rstw_s_req_clr", 64'(bus_a.o_s_req), 64'(0));
    chk("rstw_ready", 64'(bus_a.o_ready), 64'(1));
    chk("rstw_rvalid", 64'(bus_a.o_rvalid), 64'(0));
    chk("rstw_s_wren", 64'(bus_a.o_s_wren), 64'(0));
    chk("rstw_state", 64'(dbg_a), 64'(S_IDLE));
    bus_a.i_s_ack = 2'b10;
    @(posedge clk); #1;
    bus_a.i_s_ack = '0;
    chk("rstw_late_ack", 64'(bus_a.o_rvalid), 64'(0));
    @(posedge clk); #1;
    chk("rstw_late_ack2", 64'(bus_a.o_rvalid), 64'(0));
    chk("rstw_ready2", 64'(bus_a.o_ready), 64'(1));

    // Overlapping map: lowest region wins, other slave's ack ignored
    bus_b.i_s_rdata = {32'hBAD0BAD0, 32'h0000C0DE};
    bus_b.i_req = 1; bus_b.i_addr = 16'h0020; bus_b.i_wren = 0; bus_b.i_mask = 4'hF;
    @(posedge clk); #1;
    bus_b.i_req = 0;
    chk("ovl_s_req", 64'(bus_b.o_s_req), 64'(2'b01));
    chk("ovl_s_addr", 64'(bus_b.o_s_addr), 64'(16'h0020));
    bus_b.i_s_ack = 2'b10;
    @(posedge clk); #1;
    bus_b.i_s_ack = '0;
    chk("ovl_wrong_ack", 64'(bus_b.o_rvalid), 64'(0));
    chk("ovl_still_req", 64'(bus_b.o_s_req), 64'(2'b01));
    bus_b.i_s_ack = 2'b01;
    @(posedge clk); #1;
    bus_b.i_s_ack = '0;
    chk("ovl_rvalid", 64'(bus_b.o_rvalid), 64'(1));
    chk("ovl_rdata", 64'(bus_b.o_rdata), 64'(32'h0000C0DE));
    chk("ovl_err", 64'(bus_b.o_err), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
